// File: rtl/sixteen_bit_divider.sv
// 16-bit signed/unsigned restoring divider with sign fix-up and flag outputs.
// Latency: done is high after the 18th edge following the accepting edge; divide-by-zero takes 1 edge.
// Backpressure: none; start is only sampled in IDLE and is dropped while busy.
module sixteen_bit_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        signed_op,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_zero,
  output logic        overflow,
  output logic        zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  state_t      state_nxt;

  // q_reg shifts the dividend out and the quotient bits in; r_reg is the partial remainder.
  logic [15:0] q_reg;
  logic [15:0] r_reg;
  logic [15:0] b_mag;
  logic [4:0]  cnt;
  logic        neg_q;
  logic        neg_r;
  logic        dz_reg;
  logic        ov_reg;

  logic [15:0] a_mag;
  logic [15:0] b_mag_in;
  logic [16:0] rem_shift;
  logic [16:0] diff;

  assign a_mag     = (signed_op && a[15]) ? (~a + 16'd1) : a;
  assign b_mag_in  = (signed_op && b[15]) ? (~b + 16'd1) : b;
  assign rem_shift = {r_reg, q_reg[15]};
  assign diff      = rem_shift - {1'b0, b_mag};
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a zero divisor skips straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (b == 16'd0) ? DONE : CALC;
      CALC: if (cnt == 5'd15) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture magnitudes, iterate shift-subtract, then apply signs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg  <= 16'd0;
      r_reg  <= 16'd0;
      b_mag  <= 16'd0;
      cnt    <= 5'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_reg <= 1'b0;
      ov_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt    <= 5'd0;
          b_mag  <= b_mag_in;
          neg_q  <= signed_op && (a[15] ^ b[15]);
          neg_r  <= signed_op && a[15];
          dz_reg <= (b == 16'd0);
          ov_reg <= signed_op && (a == 16'h8000) && (b == 16'hFFFF);
          if (b == 16'd0) begin
            // Divide by zero: all-ones quotient, raw dividend as remainder.
            q_reg <= 16'hFFFF;
            r_reg <= a;
          end else begin
            q_reg <= a_mag;
            r_reg <= 16'd0;
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (!diff[16]) begin
            r_reg <= diff[15:0];
            q_reg <= {q_reg[14:0], 1'b1};
          end else begin
            r_reg <= rem_shift[15:0];
            q_reg <= {q_reg[14:0], 1'b0};
          end
        end
        FIX: begin
          // -32768 / -1 lands on 16'h8000 naturally since both signs match.
          if (neg_q) q_reg <= ~q_reg + 16'd1;
          if (neg_r) r_reg <= ~r_reg + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded once per operation as DONE exits, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      quotient  <= 16'd0;
      remainder <= 16'd0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        quotient  <= q_reg;
        remainder <= r_reg;
        div_zero  <= dz_reg;
        overflow  <= ov_reg;
        zero      <= (q_reg == 16'd0);
      end
    end
  end

endmodule

// File: tb/tb_sixteen_bit_divider.sv
// Directed self-checking bench for sixteen_bit_divider.
// Checks latency, results, flags, reset abort and held-start behaviour.
// Inputs change #1 after rising edges; outputs are sampled at the same point.
module tb_sixteen_bit_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        signed_op;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;
  logic        overflow;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  sixteen_bit_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .signed_op (signed_op),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and check its latency, results and the one-cycle done pulse.
  // Caller is positioned #1 after a rising edge with the DUT idle.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic ts, input int exp_lat, input logic [15:0] eq,
                        input logic [15:0] er, input logic edz, input logic eov,
                        input logic ez);
    int  lat;
    bit  busy_ok;
    a = ta; b = tb_; signed_op = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble operands after capture; results must not change.
    a = ~ta; b = ~tb_; signed_op = ~ts;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy_during"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, " quotient"}, {16'd0, quotient}, {16'd0, eq});
    chk({tag, " remainder"}, {16'd0, remainder}, {16'd0, er});
    chk({tag, " flags dz/ov/zero"}, {29'd0, div_zero, overflow, zero}, {29'd0, edz, eov, ez});
    @(posedge clk); #1;
    chk({tag, " done_pulse_ends"}, {31'd0, done}, 32'd0);
    chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, " quotient_hold"}, {16'd0, quotient}, {16'd0, eq});
  endtask

  initial begin
    int lat;
    int dones;
    rst = 1'b0; start = 1'b0; a = 16'd0; b = 16'd0; signed_op = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset outputs", {22'd0, busy, done, div_zero, overflow, zero, 5'd0},  32'd0);
    chk("reset results", {quotient, remainder}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Start in the first clock after reset release.
    run_op("u100/7",      16'd100,   16'd7,      1'b0, 18, 16'd14,    16'd2,     1'b0, 1'b0, 1'b0);
    run_op("s-7/2",       16'hFFF9,  16'd2,      1'b1, 18, 16'hFFFD,  16'hFFFF,  1'b0, 1'b0, 1'b0);
    run_op("s7/-2",       16'd7,     16'hFFFE,   1'b1, 18, 16'hFFFD,  16'd1,     1'b0, 1'b0, 1'b0);
    run_op("s-100/7",     16'hFF9C,  16'd7,      1'b1, 18, 16'hFFF2,  16'hFFFE,  1'b0, 1'b0, 1'b0);
    run_op("uFFFF/1",     16'hFFFF,  16'd1,      1'b0, 18, 16'hFFFF,  16'd0,     1'b0, 1'b0, 1'b0);
    run_op("u1234/0",     16'h1234,  16'd0,      1'b0, 1,  16'hFFFF,  16'h1234,  1'b1, 1'b0, 1'b0);
    run_op("s8000/0",     16'h8000,  16'd0,      1'b1, 1,  16'hFFFF,  16'h8000,  1'b1, 1'b0, 1'b0);
    run_op("s8000/FFFF",  16'h8000,  16'hFFFF,   1'b1, 18, 16'h8000,  16'd0,     1'b0, 1'b1, 1'b0);
    run_op("u8000/FFFF",  16'h8000,  16'hFFFF,   1'b0, 18, 16'd0,     16'h8000,  1'b0, 1'b0, 1'b1);

    // Reset during CALC aborts the operation and clears outputs at once.
    a = 16'd100; b = 16'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midreset outputs", {27'd0, busy, done, div_zero, overflow, zero}, 32'd0);
    chk("midreset results", {quotient, remainder}, 32'd0);
    #2 rst = 1'b0;
    run_op("after_reset u100/7", 16'd100, 16'd7, 1'b0, 18, 16'd14, 16'd2, 1'b0, 1'b0, 1'b0);

    // start held high through an operation with operands changing after capture.
    a = 16'd1000; b = 16'd10; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'd5; b = 16'd3; signed_op = 1'b1;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("held latency", lat, 18);
    chk("held quotient", {16'd0, quotient}, 32'd100);
    chk("held remainder", {16'd0, remainder}, 32'd0);
    dones = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("held no_extra_done", dones, 0);
    chk("held idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
